// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the timing-fabric counters
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int COUNT_W_DEFAULT = 4;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with start/done handshake, pause and auto-reload
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      reload <= '0;
      count  <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      reload <= reload_n;
      count  <= count_n;
      done   <= done_n;
      busy   <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    reload_n = reload;
    count_n  = count;
    done_n   = 1'b0;
    if (load) begin
      reload_n = load_data;
      count_n  = load_data;
      state_n  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) state_n = RUN;
            // A held start on an empty timer must not stretch done past one cycle.
            else if (!done)  done_n  = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            count_n = '0;
            done_n  = 1'b1;
          end else if (auto_reload && reload != '0) begin
            count_n = reload;
          end else begin
            state_n = IDLE;
          end
        end
        PAUSED: begin
          if (!pause) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed self-checking bench for countdown_timer
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, load, start, pause, auto_reload;
  logic [W-1:0] load_data;
  logic [W-1:0] count;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: remaining ticks, reload value, running/paused flags, done flag.
  int m_count, m_reload;
  bit m_running, m_paused, m_done;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit new_done = 0;
    if (reset) begin
      m_count = 0; m_reload = 0; m_running = 0; m_paused = 0;
    end else if (load) begin
      m_count = load_data; m_reload = load_data; m_running = 0; m_paused = 0;
    end else if (m_paused) begin
      if (!pause) begin m_paused = 0; m_running = 1; end
    end else if (m_running) begin
      if (pause) begin
        m_running = 0; m_paused = 1;
      end else if (m_count > 0) begin
        m_count = m_count - 1;
        new_done = (m_count == 0);
      end else if (auto_reload && m_reload != 0) begin
        m_count = m_reload;
      end else begin
        m_running = 0;
      end
    end else if (start) begin
      if (m_count != 0) m_running = 1;
      else new_done = !m_done;
    end
    m_done = new_done;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("count", 32'(count), 32'(m_count));
    check("busy", 32'(busy), 32'(m_running | m_paused));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    reset = 0; load = 0; start = 0; pause = 0; auto_reload = 0; load_data = '0;
  endtask

  task automatic do_load(input int v);
    load = 1; load_data = W'(v); step(); load = 0;
  endtask

  int ndone, first, k;

  initial begin
    idle_inputs();
    m_count = 0; m_reload = 0; m_running = 0; m_paused = 0; m_done = 0;
    reset = 1; step(); step(); reset = 0;
    check("reset_count", 32'(count), 0);

    do_load(7);
    check("load7_count", 32'(count), 7);
    check("load7_busy", 32'(busy), 0);

    // Plain run of 7: done after exactly 7 edges past start, once.
    start = 1; step(); start = 0;
    ndone = 0; first = -1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (done) begin
        ndone++;
        if (first < 0) first = i;
        check("done_at_zero", 32'(count), 0);
      end
    end
    check("run7_done_pos", 32'(first), 7);
    check("run7_done_cnt", 32'(ndone), 1);
    check("run7_busy_end", 32'(busy), 0);

    // Auto-reload period of 4 with load 3.
    do_load(3); auto_reload = 1;
    start = 1; step(); start = 0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin step(); if (done) ndone++; end
    check("ar_done_cnt", 32'(ndone), 3);
    check("ar_count_reload", 32'(count), 3);
    auto_reload = 0; ndone = 0;
    for (int i = 1; i <= 6; i++) begin step(); if (done) ndone++; end
    check("ar_drop_done", 32'(ndone), 1);
    check("ar_drop_idle", 32'(busy), 0);

    // Pause for 3 edges while count is 3: done shifts by 4.
    do_load(5);
    start = 1; step(); start = 0;
    step(); step();
    check("pause_pre", 32'(count), 3);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_hold", 32'(count), 3);
      check("pause_busy", 32'(busy), 1);
    end
    pause = 0;
    k = 0;
    while (!done && k < 20) begin step(); k++; end
    check("pause_done_delay", 32'(k), 4);

    // Load overrides start mid-run.
    do_load(5);
    start = 1; step(); start = 0;
    step();
    check("abort_pre", 32'(count), 4);
    load = 1; load_data = 4'd2; start = 1; step(); load = 0; start = 0;
    check("abort_count", 32'(count), 2);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    step(); step();
    check("abort_stays", 32'(count), 2);

    // Start on an empty timer: single done, never busy.
    do_load(0);
    start = 1; step(); start = 0;
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    step();
    check("zero_done_clr", 32'(done), 0);

    // Reset mid-run.
    do_load(9);
    start = 1; step(); start = 0;
    step(); step();
    reset = 1; step(); reset = 0;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 29) == 0);
      load_data   = W'($urandom_range(0, 15));
      start       = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 4) == 0);
      auto_reload = ($urandom_range(0, 2) != 0);
      step();
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer with a start/done handshake, pause and auto-reload. It is the counting-down counterpart of the team's loadable up-counter and uses the same `load`/`load_data` interface. It sits beside that counter in the timing fabric and produces one-cycle `done` pulses that downstream logic uses as timeouts or periodic ticks.

## Interface
- `WIDTH`, 4, width of the count and reload registers.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `load_data` into the reload and count registers; aborts any run.
- `load_data`  in  WIDTH  reload value.
- `start`  in  1  begin a countdown; sampled only in IDLE.
- `pause`  in  1  level; while high in RUN/PAUSED, count holds.
- `auto_reload`  in  1  level; when high, count restarts from the reload value after reaching 0.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high in RUN or PAUSED.
- `done`  out  1  one-cycle pulse, registered, asserted in the cycle `count` first reads 0 for a period.

## Operation
- States: IDLE, RUN, PAUSED.
- Priority on each edge: `reset` > `load` > `start`/`pause` > counting.
- **reset**
  - `count`=0, reload=0, state=IDLE.
  - `busy`=0, `done`=0.
- **load** (any state)
  - reload ← `load_data`; `count` ← `load_data`.
  - state → IDLE; `done` ← 0.
  - `start` in the same cycle is ignored.
- **IDLE**
  - `start`=1 with `count`≠0: → RUN; `count` unchanged on this edge.
  - `start`=1 with `count`=0: stay IDLE; `done` pulses next cycle.
- **RUN, `pause`=1**: → PAUSED; `count` held on this edge.
- **RUN, `pause`=0, `count`>1**: `count` ← `count`−1.
- **RUN, `pause`=0, `count`=1**: `count` ← 0; `done` ← 1.
- **RUN, `pause`=0, `count`=0**:
  - If `auto_reload`=1 and reload≠0: `count` ← reload; stay RUN.
  - Otherwise: → IDLE.
- **PAUSED**
  - `pause`=0: → RUN; decrement resumes on the following edge.
  - `pause`=1: hold.
- `start` is ignored in RUN and PAUSED.
- Width rules: unsigned arithmetic. `count` never wraps below 0; the only path from 0 to a nonzero value is reload or load.
- `auto_reload` is sampled only at the `count`=0 decision in RUN. Dropping it mid-period finishes the current period, then returns to IDLE.

## Timing
- `load` at edge E: `count`=`load_data` after E.
- `start` accepted at edge S: RUN after S.
  - With reload value N: `count` reads N−1 after S+1 and 0 after S+N.
  - `done`=1 during the cycle after S+N.
  - `busy` high from after S until after S+N+1.
- Auto-reload period: N+1 cycles, one `done` per period (sequence N, N−1, …, 0, N, …).
- Pause: each cycle spent in PAUSED plus one resume cycle extends the run by that many cycles. `done` timing shifts accordingly.
- `done` never stays high for more than one consecutive cycle.
- `busy` and `count` are glitch-free registered outputs.

## Structure
- Package `counter_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSED).
  - `COUNT_W_DEFAULT` = 4.
- Single module. No sub-module is needed: next-state/next-count logic is in one combinational block, and the registers are in one `always_ff` with a synchronous `reset`.

## Test plan
- Reset, then `load`=1 with `load_data`=7 for one cycle → `count`=7, `busy`=0, `done`=0.
- Load 7, pulse `start` → `count` 7,6,…,0 on successive cycles; `done`=1 exactly once with `count`=0; `busy` falls the next cycle.
- Load 3, `auto_reload`=1, `start` → `count` 3,2,1,0,3,2,1,0,…; `done` every 4 cycles; drop `auto_reload` → stops in IDLE after the next 0.
- Load 5, start, hold `pause` for 3 cycles while `count`=3 → `count` holds at 3 and `busy` stays 1; after release, `done` arrives 4 cycles later than the unpaused run.
- `load`=1 with `load_data`=2 while RUN at `count`=4, `start` asserted the same cycle → IDLE, `count`=2, no `done`.
- Load 0, `start` → `done` pulses once next cycle; `busy` stays 0. Separately, assert `reset` mid-run → `count`=0, IDLE, `done`=0 on the next cycle.
